// File: rtl/serdes_pkg.sv
// Shared serdes definitions: word geometry, length codes and
// the deserializer state encoding.
package serdes_pkg;

  localparam int DATA_W = 16;
  localparam int MOD_W  = $clog2(DATA_W);

  typedef logic [MOD_W-1:0] mod_t;

  typedef enum logic {
    IDLE,
    RECV
  } deser_state_t;

  function automatic mod_t len2mod(input int unsigned len);
    return mod_t'(len % DATA_W);
  endfunction

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: MSB-first bits are written by index
// into a word register; full or terminated runs are reported with a length code.
module deserializer #(
  parameter int DATA_W  = serdes_pkg::DATA_W,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int MIN_LEN = 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              data_i,
  input  logic              data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  import serdes_pkg::*;

  localparam logic [MOD_W-1:0] LAST  = MOD_W'(DATA_W - 1);
  localparam logic [MOD_W:0]   MIN_L = (MOD_W + 1)'(MIN_LEN);

  deser_state_t      state;
  deser_state_t      state_nxt;
  logic [MOD_W-1:0]  cnt;
  logic [MOD_W-1:0]  idx;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_nxt;
  logic              last_bit;
  logic              run_end;
  logic              emit;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (srst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a run ends on val drop or on the last bit of a word
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (data_val_i) state_nxt = RECV;
      RECV: if (!data_val_i || cnt == LAST) state_nxt = IDLE;
    endcase
  end

  // Decode: write index, word completion and next word contents
  always_comb begin
    idx      = LAST - cnt;
    last_bit = (state == RECV) && data_val_i && (cnt == LAST);
    run_end  = (state == RECV) && !data_val_i;
    emit     = last_bit || (run_end && ({1'b0, cnt} >= MIN_L));
    sr_nxt   = sr;
    if (data_val_i) begin
      if (state == IDLE) begin
        sr_nxt           = '0;
        sr_nxt[DATA_W-1] = data_i;
      end else begin
        sr_nxt[idx] = data_i;
      end
    end
  end

  // Bit counter wraps to zero on a full word; busy tracks it
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt    <= '0;
      busy_o <= 1'b0;
    end else if (data_val_i) begin
      cnt    <= cnt + 1'b1;
      busy_o <= (cnt != LAST);
    end else begin
      cnt    <= '0;
      busy_o <= 1'b0;
    end
  end

  // Word register under assembly
  always_ff @(posedge clk_i) begin
    if (srst_i) sr <= '0;
    else        sr <= sr_nxt;
  end

  // Output register, loaded only on completion so it holds otherwise
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      deser_data_o     <= '0;
      deser_mod_o      <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      deser_data_val_o <= emit;
      if (emit) begin
        deser_data_o <= sr_nxt;
        deser_mod_o  <= last_bit ? '0 : cnt;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Randomized and directed bench for deserializer, two instances
// (MIN_LEN 1 and 3) checked against a run-level queue model.
module tb_deserializer;

  import serdes_pkg::*;

  typedef struct {
    int          c;
    logic [15:0] d;
    logic [3:0]  m;
  } ev_t;

  logic        clk;
  logic        srst;
  logic        din;
  logic        dval;
  logic        vo   [2];
  logic [15:0] dat  [2];
  logic [3:0]  mo   [2];
  logic        bz   [2];

  int          total;
  int          bad;
  int          cyc;
  int          clr_at;
  bit          armed;
  int          minl [2];
  ev_t         exq  [2][$];
  logic        run  [2][$];
  logic [15:0] last_d [2];
  logic [3:0]  last_m [2];

  deserializer #(.MIN_LEN(1)) dut (
    .clk_i           (clk),
    .srst_i          (srst),
    .data_i          (din),
    .data_val_i      (dval),
    .deser_data_o    (dat[0]),
    .deser_mod_o     (mo[0]),
    .deser_data_val_o(vo[0]),
    .busy_o          (bz[0])
  );

  deserializer #(.MIN_LEN(3)) dut3 (
    .clk_i           (clk),
    .srst_i          (srst),
    .data_i          (din),
    .data_val_i      (dval),
    .deser_data_o    (dat[1]),
    .deser_mod_o     (mo[1]),
    .deser_data_val_o(vo[1]),
    .busy_o          (bz[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Build the word a run represents and schedule its pulse
  task automatic emit(input int k, input int at);
    ev_t e;
    e.d = '0;
    for (int i = 0; i < run[k].size(); i++)
      e.d[15-i] = run[k][i];
    e.m = len2mod(run[k].size());
    e.c = at;
    exq[k].push_back(e);
  endtask

  // One clock of stimulus plus the model update for that cycle
  task automatic step(input logic v, input logic b, input logic r);
    @(posedge clk);
    #1;
    if (armed)
      for (int k = 0; k < 2; k++)
        chk($sformatf("busy%0d", k), 32'(bz[k]),
            32'(run[k].size() != 0));
    dval = v;
    din  = v ? b : 1'($urandom);
    srst = r;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        run[k].delete();
        clr_at = cyc + 1;
      end else if (v) begin
        run[k].push_back(b);
        if (run[k].size() == DATA_W) begin
          emit(k, cyc + 1);
          run[k].delete();
        end
      end else if (run[k].size() > 0) begin
        if (run[k].size() >= minl[k]) emit(k, cyc + 1);
        run[k].delete();
      end
    end
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    logic [31:0] t;
    t = w;
    for (int i = n - 1; i >= 0; i--) step(1'b1, t[i], 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  // Pulse/hold monitor sampled away from the active edge
  always @(negedge clk) begin
    ev_t ev;
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        if (cyc == clr_at) begin
          last_d[k] = '0;
          last_m[k] = '0;
        end
        while (exq[k].size() > 0 && exq[k][0].c < cyc) begin
          chk($sformatf("miss%0d", k), cyc, exq[k][0].c);
          void'(exq[k].pop_front());
        end
        if (vo[k]) begin
          if (exq[k].size() == 0) begin
            chk($sformatf("spur%0d", k), 32'(vo[k]), 0);
          end else if (exq[k][0].c != cyc) begin
            chk($sformatf("early%0d", k), cyc, exq[k][0].c);
          end else begin
            ev = exq[k].pop_front();
            chk($sformatf("data%0d", k), 32'(dat[k]), 32'(ev.d));
            chk($sformatf("mod%0d", k), 32'(mo[k]), 32'(ev.m));
            last_d[k] = ev.d;
            last_m[k] = ev.m;
          end
        end else begin
          chk($sformatf("hold_d%0d", k), 32'(dat[k]), 32'(last_d[k]));
          chk($sformatf("hold_m%0d", k), 32'(mo[k]), 32'(last_m[k]));
        end
      end
    end
  end

  logic [15:0] lb_d [4];
  logic [3:0]  lb_m [4];

  initial begin
    int len;
    total   = 0;
    bad     = 0;
    cyc     = 0;
    clr_at  = -1;
    armed   = 1'b0;
    minl[0] = 1;
    minl[1] = 3;
    for (int k = 0; k < 2; k++) begin
      last_d[k] = '0;
      last_m[k] = '0;
    end
    srst = 1'b1;
    dval = 1'b0;
    din  = 1'b0;

    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    armed = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_val",  32'(vo[k]),  0);
      chk("rst_data", 32'(dat[k]), 0);
      chk("rst_mod",  32'(mo[k]),  0);
      chk("rst_busy", 32'(bz[k]),  0);
    end
    step(1'b0, 1'b0, 1'b0);

    // sixteen ones
    send_bits(32'hFFFF, 16);
    idle(3);
    // fourteen-bit partial
    send_bits(32'h2222, 14);
    idle(3);
    // two-bit run, below MIN_LEN for the second instance
    send_bits(32'h2, 2);
    idle(3);
    // full word followed directly by a four-bit tail
    send_bits(32'hA5A5B, 20);
    idle(3);
    // reset drops a partial word
    send_bits(32'h55, 7);
    step(1'b0, 1'b0, 1'b1);
    send_bits(32'h1234, 16);
    idle(3);
    // reset asserted while bits are still arriving
    send_bits(32'h3F, 6);
    step(1'b1, 1'b1, 1'b1);
    idle(2);

    // serializer loopback words
    lb_d[0] = 16'hFFFF; lb_m[0] = 4'd0;
    lb_d[1] = 16'h8888; lb_m[1] = 4'd14;
    lb_d[2] = 16'hAAAA; lb_m[2] = 4'd2;
    lb_d[3] = 16'hB8AA; lb_m[3] = 4'd12;
    for (int i = 0; i < 4; i++) begin
      len = (lb_m[i] == 0) ? 16 : int'(lb_m[i]);
      send_bits(32'(lb_d[i]) >> (16 - len), len);
      idle(2);
    end

    // random runs, gaps and occasional resets
    repeat (80) begin
      len = $urandom_range(1, 40);
      repeat (len) step(1'b1, 1'($urandom), 1'b0);
      if ($urandom_range(0, 9) == 0) step(1'b0, 1'b0, 1'b1);
      idle($urandom_range(0, 3));
    end

    idle(4);
    for (int k = 0; k < 2; k++)
      chk($sformatf("left%0d", k), exq[k].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
